// File: rtl/obstacle_spawner.sv
// ---------------------------------------------------------------------------
// obstacle_spawner
//
// Feeds the four lane shift registers with pseudo-random obstacles. Once per
// game tick it produces a 4-bit entry word that is either all zero or has
// exactly one lane bit set. A small game-state machine (IDLE/RUN/PAUSE/OVER)
// decides when spawning is allowed.
//
// Parameters:
//   SEED        LFSR reset value; must be nonzero or the LFSR locks up
//   MIN_GAP     ticks forced empty after every spawn (0..7)
//   MAX_REPEAT  longest run of consecutive spawns allowed in one lane (1..3)
//
// Ports:
//   clock        system clock
//   Reset_b      asynchronous reset, active low
//   tick         one-cycle game-step enable from the rate divider
//   start        level, begins or restarts a game
//   pause        level, holds the game while high
//   game_over    level, registered hit flag from the collision logic
//   density      spawn probability select (64/96/128/192 out of 256)
//   osignal      lane entry word, bit i = lane i, one-hot or zero
//   spawn_count  obstacles spawned in the current game, saturates at 255
//   state        game state: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
// ---------------------------------------------------------------------------
module obstacle_spawner #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MIN_GAP    = 1,
    parameter int          MAX_REPEAT = 2
) (
    input  logic       clock,
    input  logic       Reset_b,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    input  logic [1:0] density,
    output logic [3:0] osignal,
    output logic [7:0] spawn_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    game_state_t state_q;
    game_state_t state_d;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [2:0]  gap_cnt;
    logic [1:0]  last_lane;
    logic [1:0]  repeat_cnt;

    logic [7:0]  threshold;
    logic [1:0]  cand_lane;
    logic [1:0]  spawn_lane;
    logic        spawn_hit;
    logic        eval_en;
    logic        game_start;

    assign state = state_q;

    // Next-state logic, evaluated every clock rather than only on ticks so the
    // game reacts to buttons and the hit flag immediately. game_over outranks
    // pause, which outranks start. A start while the hit flag is still high is
    // ignored so a game cannot restart straight into a collision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            OVER: begin
                if (start && !game_over) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Game state register.
    always_ff @(posedge clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Right-shifting Galois LFSR with taps 16,14,13,11 (mask 16'hB400). It runs
    // every cycle in every state, so the sequence seen by the first tick of a
    // game depends on how long the player took to press start.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ 16'hB400;
        end
    end

    // Spawn decision for the current cycle. The low LFSR byte is compared with
    // a density-dependent threshold; bits 9:8 propose a lane. If that lane has
    // already received MAX_REPEAT consecutive spawns, the obstacle is moved to
    // the next lane (wrapping 3 -> 0) to keep the game playable. A decision is
    // only taken on a tick where the game is in RUN and stays in RUN; any state
    // change on the same cycle wins over the tick.
    always_comb begin
        threshold = 8'd64;
        case (density)
            2'd0:    threshold = 8'd64;
            2'd1:    threshold = 8'd96;
            2'd2:    threshold = 8'd128;
            default: threshold = 8'd192;
        endcase

        cand_lane  = lfsr[9:8];
        spawn_lane = cand_lane;
        if ((cand_lane == last_lane) && (repeat_cnt == 2'(MAX_REPEAT))) begin
            spawn_lane = cand_lane + 2'd1;
        end

        spawn_hit  = (lfsr[7:0] < threshold);
        eval_en    = tick && (state_q == RUN) && (state_d == RUN);
        game_start = ((state_q == IDLE) || (state_q == OVER)) && (state_d == RUN);
    end

    // Datapath registers. osignal is registered, so a decision taken on a tick
    // appears on the following cycle and is held until the next tick. Leaving
    // RUN clears it at once. Entering a new game clears the counters but keeps
    // last_lane; PAUSE leaves gap and repeat bookkeeping untouched so the game
    // resumes exactly where it stopped.
    always_ff @(posedge clock or negedge Reset_b) begin
        if (!Reset_b) begin
            lfsr        <= SEED;
            osignal     <= 4'b0000;
            spawn_count <= 8'd0;
            gap_cnt     <= 3'd0;
            last_lane   <= 2'd0;
            repeat_cnt  <= 2'd0;
        end else begin
            lfsr <= lfsr_next;

            if (game_start) begin
                spawn_count <= 8'd0;
                gap_cnt     <= 3'd0;
                repeat_cnt  <= 2'd0;
            end

            if (state_d != RUN) begin
                osignal <= 4'b0000;
            end else if (eval_en) begin
                if (gap_cnt != 3'd0) begin
                    gap_cnt <= gap_cnt - 3'd1;
                    osignal <= 4'b0000;
                end else if (spawn_hit) begin
                    osignal    <= 4'b0001 << spawn_lane;
                    repeat_cnt <= (spawn_lane == last_lane) ? (repeat_cnt + 2'd1) : 2'd1;
                    last_lane  <= spawn_lane;
                    gap_cnt    <= 3'(MIN_GAP);
                    if (spawn_count != 8'hFF) begin
                        spawn_count <= spawn_count + 8'd1;
                    end
                end else begin
                    osignal <= 4'b0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// ---------------------------------------------------------------------------
// tb_obstacle_spawner
//
// Drives two spawners from the same inputs: dutA with the default MIN_GAP of 1
// and dutB with MIN_GAP 0. The driver applies one input vector per cycle on
// the falling edge, advances a reference model of both spawners and queues the
// outputs expected after the next rising edge. A separate monitor pops one
// entry per rising edge and compares, and also checks the one-hot, gap and
// lane-repeat properties on every evaluated tick. The driver adds hand-worked
// checks for reset, the first spawns after reset and the FSM scenarios.
// ---------------------------------------------------------------------------
module tb_obstacle_spawner;

    logic       clock = 1'b0;
    logic       Reset_b;
    logic       tick;
    logic       start;
    logic       pause;
    logic       game_over;
    logic [1:0] density;

    logic [3:0] osig_a;
    logic [7:0] cnt_a;
    logic [1:0] st_a;
    logic [3:0] osig_b;
    logic [7:0] cnt_b;
    logic [1:0] st_b;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic [15:0] lfsr;
        logic [1:0]  st;
        logic [3:0]  osig;
        logic [7:0]  cnt;
        logic [2:0]  gap;
        logic [1:0]  last;
        logic [1:0]  rep;
    } model_t;

    typedef struct packed {
        model_t a;
        model_t b;
    } exp_t;

    exp_t   expQ[$];
    exp_t   monE;
    model_t mdlA;
    model_t mdlB;

    logic [1:0] prevSt      = 2'b00;
    logic       lastSpawnA  = 1'b0;
    logic [1:0] lastLaneB   = 2'b00;
    int         runB        = 0;
    int         spawnsA     = 0;
    int         spawnsB     = 0;
    int         evalTicksA  = 0;
    logic [7:0] savedCnt;

    obstacle_spawner dutA (
        .clock       (clock),
        .Reset_b     (Reset_b),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .game_over   (game_over),
        .density     (density),
        .osignal     (osig_a),
        .spawn_count (cnt_a),
        .state       (st_a)
    );

    obstacle_spawner #(.MIN_GAP(0)) dutB (
        .clock       (clock),
        .Reset_b     (Reset_b),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .game_over   (game_over),
        .density     (density),
        .osignal     (osig_b),
        .spawn_count (cnt_b),
        .state       (st_b)
    );

    // 100 MHz bench clock; the absolute rate is irrelevant to the design.
    always #5 clock = ~clock;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference state after an asynchronous reset.
    function automatic model_t modelReset();
        model_t m;
        m      = '0;
        m.lfsr = 16'hACE1;
        return m;
    endfunction

    // Reference behaviour of one spawner across one rising edge, MAX_REPEAT=2.
    function automatic model_t modelStep(input model_t m, input int minGap,
                                         input logic tk, input logic strt,
                                         input logic ps, input logic go,
                                         input logic [1:0] dens);
        model_t     n;
        logic [1:0] nst;
        logic [1:0] lane;
        logic [7:0] thr;
        n   = m;
        nst = m.st;
        case (m.st)
            2'b00:   if (strt) nst = 2'b01;
            2'b01:   if (go) nst = 2'b11; else if (ps) nst = 2'b10;
            2'b10:   if (go) nst = 2'b11; else if (!ps) nst = 2'b01;
            default: if (strt && !go) nst = 2'b01;
        endcase
        n.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 16'hB400) : (m.lfsr >> 1);
        n.st   = nst;
        if ((m.st == 2'b00 || m.st == 2'b11) && nst == 2'b01) begin
            n.cnt = 8'd0;
            n.gap = 3'd0;
            n.rep = 2'd0;
        end
        if (nst != 2'b01) begin
            n.osig = 4'b0000;
        end else if (m.st == 2'b01 && tk) begin
            if (m.gap != 3'd0) begin
                n.gap  = m.gap - 3'd1;
                n.osig = 4'b0000;
            end else begin
                case (dens)
                    2'd0:    thr = 8'd64;
                    2'd1:    thr = 8'd96;
                    2'd2:    thr = 8'd128;
                    default: thr = 8'd192;
                endcase
                if (m.lfsr[7:0] < thr) begin
                    lane = m.lfsr[9:8];
                    if (lane == m.last && m.rep == 2'd2) lane = lane + 2'd1;
                    n.osig = 4'b0001 << lane;
                    n.rep  = (lane == m.last) ? m.rep + 2'd1 : 2'd1;
                    n.last = lane;
                    n.gap  = 3'(minGap);
                    n.cnt  = (m.cnt == 8'd255) ? 8'd255 : m.cnt + 8'd1;
                end else begin
                    n.osig = 4'b0000;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [1:0] laneOf(input logic [3:0] o);
        logic [1:0] l;
        l = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (o[i]) l = 2'(i);
        end
        return l;
    endfunction

    // One input vector per cycle, applied on the falling edge, with the
    // expected post-edge outputs of both spawners queued for the monitor.
    task automatic applyStimulus(input logic rstN, input logic tk, input logic strt,
                                 input logic ps, input logic go, input logic [1:0] dens);
        exp_t e;
        @(negedge clock);
        Reset_b   = rstN;
        tick      = tk;
        start     = strt;
        pause     = ps;
        game_over = go;
        density   = dens;
        if (!rstN) begin
            mdlA = modelReset();
            mdlB = modelReset();
        end else begin
            mdlA = modelStep(mdlA, 1, tk, strt, ps, go, dens);
            mdlB = modelStep(mdlB, 0, tk, strt, ps, go, dens);
        end
        e.a = mdlA;
        e.b = mdlB;
        expQ.push_back(e);
    endtask

    // n ticks spaced 'period' cycles apart with the given level inputs.
    task automatic runTicks(input int n, input int period, input logic ps,
                            input logic go, input logic [1:0] dens);
        for (int k = 0; k < n; k++) begin
            repeat (period - 1) applyStimulus(1'b1, 1'b0, 1'b0, ps, go, dens);
            applyStimulus(1'b1, 1'b1, 1'b0, ps, go, dens);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 ns later, plus
    // the structural properties on every tick that evaluated a spawn.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkOutput("state_a", int'(st_a), int'(monE.a.st));
                checkOutput("osignal_a", int'(osig_a), int'(monE.a.osig));
                checkOutput("count_a", int'(cnt_a), int'(monE.a.cnt));
                checkOutput("state_b", int'(st_b), int'(monE.b.st));
                checkOutput("osignal_b", int'(osig_b), int'(monE.b.osig));
                checkOutput("count_b", int'(cnt_b), int'(monE.b.cnt));
                checkOutput("onehot_a", int'($countones(osig_a) <= 1), 1);
                checkOutput("onehot_b", int'($countones(osig_b) <= 1), 1);

                if (monE.a.st == 2'b01 && (prevSt == 2'b00 || prevSt == 2'b11)) begin
                    spawnsA    = 0;
                    spawnsB    = 0;
                    evalTicksA = 0;
                    runB       = 0;
                    lastSpawnA = 1'b0;
                end

                if (Reset_b && tick && prevSt == 2'b01 && monE.a.st == 2'b01) begin
                    evalTicksA++;
                    if (lastSpawnA) checkOutput("gap_a", int'(osig_a), 0);
                    lastSpawnA = (osig_a != 4'b0000);
                    if (osig_a != 4'b0000) spawnsA++;
                    if (osig_b != 4'b0000) begin
                        spawnsB++;
                        if (runB > 0 && laneOf(osig_b) == lastLaneB) runB++;
                        else runB = 1;
                        lastLaneB = laneOf(osig_b);
                        checkOutput("repeat_b", int'(runB <= 2), 1);
                    end
                end
                prevSt = monE.a.st;
            end
        end
    end

    // Directed sequence with hand-worked expectations.
    initial begin
        Reset_b   = 1'b0;
        tick      = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
        density   = 2'd3;
        mdlA      = modelReset();
        mdlB      = modelReset();

        // Power-on reset.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("reset_state", int'(st_a), 0);
        checkOutput("reset_osignal", int'(osig_a), 0);
        checkOutput("reset_count", int'(cnt_b), 0);

        // Release with start: first tick sees lfsr 16'hE270, low byte 0x70 <
        // 192 and lane bits 2'b10, so both spawners put an obstacle in lane 2.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("start_to_run", int'(st_a), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("first_spawn_a", int'(osig_a), 4);
        checkOutput("first_spawn_b", int'(osig_b), 4);
        checkOutput("first_count", int'(cnt_a), 1);

        // Asynchronous reset while lane 2 is showing.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        #1;
        checkOutput("async_rst_osignal", int'(osig_a), 0);
        checkOutput("async_rst_state", int'(st_a), 0);
        checkOutput("async_rst_count", int'(cnt_a), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

        // Same sequence again proves the LFSR restarted from its seed. The
        // second tick sees 16'h7138: dutA is in its gap, dutB spawns lane 1.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("reseed_spawn_a", int'(osig_a), 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("reseed_gap_a", int'(osig_a), 0);
        checkOutput("reseed_lane1_b", int'(osig_b), 2);
        checkOutput("reseed_count_b", int'(cnt_b), 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("hold_no_tick_b", int'(osig_b), 2);

        // Sweep all densities.
        for (int i = 0; i < 40; i++) runTicks(1, 3, 1'b0, 1'b0, 2'(i % 4));

        // Pause for five ticks, then resume.
        savedCnt = mdlA.cnt;
        runTicks(5, 2, 1'b1, 1'b0, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        checkOutput("pause_state", int'(st_a), 2);
        checkOutput("pause_osignal", int'(osig_b), 0);
        checkOutput("pause_count_frozen", int'(cnt_a), int'(savedCnt));
        runTicks(4, 2, 1'b0, 1'b0, 2'd3);
        checkOutput("resume_state", int'(st_b), 1);

        // Tick together with game_over, start blocked by game_over, restart.
        savedCnt = mdlB.cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
        checkOutput("over_state", int'(st_a), 3);
        checkOutput("over_osignal", int'(osig_b), 0);
        checkOutput("over_count_kept", int'(cnt_b), int'(savedCnt));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
        checkOutput("start_blocked", int'(st_a), 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        checkOutput("over_hold", int'(st_b), 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("restart_state", int'(st_a), 1);
        checkOutput("restart_count", int'(cnt_a), 0);

        // Long dense run: saturation and spawn-rate bounds.
        runTicks(1000, 2, 1'b0, 1'b0, 2'd3);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("saturate_a", int'(cnt_a), 255);
        checkOutput("saturate_b", int'(cnt_b), 255);
        checkOutput("rate_b_650_850", int'(spawnsB >= 650 && spawnsB <= 850), 1);
        checkOutput("gap_ratio_a", int'(spawnsA * 2 <= evalTicksA + 1), 1);

        @(posedge clock);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Upstream feeder for the four lane shift registers; replaces switch-driven obstacle entry with pseudo-random generation.
- Produces a one-hot (or all-zero) 4-bit obstacle word per game tick.
- A small game-state FSM (IDLE/RUN/PAUSE/OVER) gates spawning.
- Consumes the divided-clock tick pulse and the registered hit flag; drives the lane-entry bits.

Parameters:
SEED, 16'hACE1, LFSR reset value; must be nonzero (zero is illegal, LFSR would lock).
MIN_GAP, 1, number of ticks forced empty after each spawn (0..7).
MAX_REPEAT, 2, max consecutive spawns allowed in the same lane (1..3).

Ports:
clock  input  1  system clock (50 MHz).
Reset_b  input  1  asynchronous reset, active-low.
tick  input  1  one-cycle enable pulse from rate divider; all game-step actions occur only on cycles with tick=1.
start  input  1  level; begins/restarts a game.
pause  input  1  level; holds the game while high.
game_over  input  1  level; hit flag from the collision flip-flop.
density  input  2  spawn probability select.
osignal  output  4  obstacle entry word, bit i = lane i; one-hot or zero.
spawn_count  output  8  obstacles spawned this game, saturating.
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.

Behaviour:
- Reset (Reset_b=0, async):
  - state=IDLE, osignal=0, spawn_count=0, lfsr=SEED, gap_cnt=0, last_lane=0, repeat_cnt=0.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Shifts right every clock cycle in every state, independent of tick, so the value at start depends on user timing.
- FSM transitions are evaluated every clock, not only on tick. Priority is reset > game_over > pause > start.
  - IDLE: start=1 -> RUN; spawn_count, gap_cnt and repeat_cnt are cleared on entry.
  - RUN: game_over=1 -> OVER; else pause=1 -> PAUSE.
  - PAUSE: game_over=1 -> OVER; else pause=0 -> RUN. gap_cnt, last_lane and repeat_cnt are frozen.
  - OVER: start=1 and game_over=0 -> RUN, with spawn_count, gap_cnt and repeat_cnt cleared. Start while game_over=1 is ignored.
- osignal is 0 in the cycle after leaving RUN and stays 0 in IDLE, PAUSE and OVER.
- Spawn decision, only on a tick cycle with state=RUN. Result is registered: osignal updates on the cycle after tick and holds until the next tick.
  1. If gap_cnt>0: gap_cnt -= 1; osignal=0.
  2. Otherwise:
     - Threshold by density: 0 -> 64, 1 -> 96, 2 -> 128, 3 -> 192.
     - Spawn if lfsr[7:0] < threshold; else osignal=0.
     - Candidate lane = lfsr[9:8].
     - If candidate==last_lane and repeat_cnt==MAX_REPEAT, lane = candidate+1 mod 4.
     - On spawn:
       - osignal = 1<<lane.
       - repeat_cnt = (lane==last_lane) ? repeat_cnt+1 : 1.
       - last_lane = lane.
       - gap_cnt = MIN_GAP.
       - spawn_count += 1, saturating at 255.
- Tick and a state change in the same cycle: the transition wins and no spawn is evaluated (e.g. tick and game_over together -> OVER, osignal=0).
- Tick in IDLE, PAUSE or OVER: no effect except the LFSR shift.
- Invariants: osignal never has more than one bit set; it never changes on a non-tick cycle while in RUN.

Test Plan:
- Reset mid-RUN with osignal=4'b0100 -> osignal=0, state=00, spawn_count=0 on the same cycle (asynchronous); after release the LFSR restarts from 16'hACE1.
- Start, density=3, MIN_GAP=0, 1000 ticks -> every osignal sample is zero or one-hot; spawn count is within 650-850 (about 75%); no lane appears more than 2 times consecutively.
- MIN_GAP=1, density=3 -> every spawn is followed by exactly one tick with osignal=0; spawn_count never exceeds half of ticks+1.
- RUN, assert pause for 5 ticks -> osignal=0, spawn_count frozen, state=10; release -> state=01 and spawning resumes on the next tick.
- tick and game_over asserted together -> state=11, osignal=0, spawn_count unchanged; start while game_over=1 -> remains 11; drop game_over then start -> state=01, spawn_count=0.
- Force spawn_count to 255 via a long run -> further spawns keep it at 255 with no wrap to 0.
